// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, 3-sample majority bit recovery,
// LSB-first deserialization and parity/stop sequencing toward the RX parity checker.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  par_err,
    output logic                  sampled_bit,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  par_chk_en,
    output logic                  data_valid,
    output logic                  par_err_flag,
    output logic                  stop_err,
    output logic                  strt_glitch,
    output logic [2:0]            state_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

    logic [2:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic                  sampled_q, sampled_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_flag_q, par_flag_d;
    logic                  par_err_flag_q, par_err_flag_d;
    logic                  stop_err_q, stop_err_d;
    logic                  data_valid_q, data_valid_d;
    logic                  glitch_c, chk_en_c;

    logic [PRESCALE_W-1:0] half, s_lo, s_hi;
    logic                  edge_last, maj;

    // Edge counter is free-running modulo 2^PRESCALE_W, so an illegal Prescale can only
    // distort timing; the bit-end compare is always reached eventually.
    assign half      = prescale_q >> 1;
    assign s_lo      = half - ONE;
    assign s_hi      = half + ONE;
    assign edge_last = (edge_cnt_q == prescale_q - ONE);
    assign maj       = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);

    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        prescale_d     = prescale_q;
        par_en_d       = par_en_q;
        bit_cnt_d      = bit_cnt_q;
        s0_d           = s0_q;
        s1_d           = s1_q;
        sampled_d      = sampled_q;
        p_data_d       = p_data_q;
        par_flag_d     = par_flag_q;
        par_err_flag_d = par_err_flag_q;
        stop_err_d     = stop_err_q;
        data_valid_d   = 1'b0;
        glitch_c       = 1'b0;
        chk_en_c       = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = edge_last ? '0 : edge_cnt_q + ONE;
            if (edge_cnt_q == s_lo) s0_d = RX_IN;
            if (edge_cnt_q == half) s1_d = RX_IN;
            if (edge_cnt_q == s_hi) sampled_d = maj;
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                prescale_d = Prescale;
                par_en_d   = PAR_EN;
                if (!RX_IN) begin
                    state_d    = START;
                    edge_cnt_d = ONE;
                end
            end
            START: begin
                if (edge_last) begin
                    if (sampled_q) begin
                        glitch_c = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d        = DATA;
                        bit_cnt_d      = '0;
                        par_flag_d     = 1'b0;
                        par_err_flag_d = 1'b0;
                        stop_err_d     = 1'b0;
                    end
                end
            end
            DATA: begin
                if (edge_last) begin
                    p_data_d = {sampled_q, p_data_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (edge_last) begin
                    chk_en_c   = 1'b1;
                    par_flag_d = par_err;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (edge_last) begin
                    stop_err_d     = ~sampled_q;
                    par_err_flag_d = par_flag_q;
                    data_valid_d   = sampled_q & ~par_flag_q;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            edge_cnt_q     <= '0;
            prescale_q     <= '0;
            par_en_q       <= 1'b0;
            bit_cnt_q      <= '0;
            s0_q           <= 1'b0;
            s1_q           <= 1'b0;
            sampled_q      <= 1'b0;
            p_data_q       <= '0;
            par_flag_q     <= 1'b0;
            par_err_flag_q <= 1'b0;
            stop_err_q     <= 1'b0;
            data_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            prescale_q     <= prescale_d;
            par_en_q       <= par_en_d;
            bit_cnt_q      <= bit_cnt_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            sampled_q      <= sampled_d;
            p_data_q       <= p_data_d;
            par_flag_q     <= par_flag_d;
            par_err_flag_q <= par_err_flag_d;
            stop_err_q     <= stop_err_d;
            data_valid_q   <= data_valid_d;
        end
    end

    assign sampled_bit  = sampled_q;
    assign P_DATA       = p_data_q;
    assign par_chk_en   = chk_en_c;
    assign data_valid   = data_valid_q;
    assign par_err_flag = par_err_flag_q;
    assign stop_err     = stop_err_q;
    assign strt_glitch  = glitch_c;
    assign state_o      = state_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; an even-parity checker model answers par_err.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_err;
  logic       sampled_bit;
  logic [7:0] p_data;
  logic       par_chk_en;
  logic       data_valid;
  logic       par_err_flag;
  logic       stop_err;
  logic       strt_glitch;
  logic [2:0] state_o;

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  logic [7:0] obs_data_q[$];
  int         obs_cyc_q[$];
  logic [7:0] exp_q[$];
  int pce_cnt = 0;
  int pce_cyc = 0;
  int sg_cnt = 0;
  int sg_cyc = 0;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(clk), .RST(rst), .RX_IN(rx_in), .Prescale(prescale), .PAR_EN(par_en),
    .par_err(par_err), .sampled_bit(sampled_bit), .P_DATA(p_data),
    .par_chk_en(par_chk_en), .data_valid(data_valid), .par_err_flag(par_err_flag),
    .stop_err(stop_err), .strt_glitch(strt_glitch), .state_o(state_o)
  );

  // even-parity checker: error when the sampled parity bit disagrees with ^P_DATA
  assign par_err = (^p_data) ^ sampled_bit;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, run incomplete");
    $fatal(1, "watchdog");
  end

  // monitor: outputs sampled mid-cycle
  always @(negedge clk) begin
    if (data_valid) begin
      obs_data_q.push_back(p_data);
      obs_cyc_q.push_back(cyc);
    end
    if (par_chk_en) begin
      pce_cnt = pce_cnt + 1;
      pce_cyc = cyc;
    end
    if (strt_glitch) begin
      sg_cnt = sg_cnt + 1;
      sg_cyc = cyc;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic send_frame(input int p, input logic [7:0] data, input logic pe,
                            input logic pbit, input logic sbit, input int glitch_at,
                            input int stop_at, output int t0);
    logic [10:0] frame;
    int nbits;
    logic v;
    nbits = pe ? 11 : 10;
    frame = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[1+i] = data[i];
    if (pe) frame[9] = pbit;
    frame[nbits-1] = sbit;
    t0 = 0;
    for (int n = 0; n < nbits * p; n++) begin
      if (n == stop_at) break;
      @(negedge clk);
      if (n == 0) begin
        t0 = cyc;
        prescale = 6'(p);
        par_en = pe;
      end
      v = frame[n / p];
      if (n == glitch_at) v = ~v;
      rx_in = v;
    end
  endtask

  // tests
  task automatic test_reset;
    rst = 1'b1;
    rx_in = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state_o !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", state_o); end
    tests_run++;
    if (p_data !== 8'h00) begin tests_failed++; $display("FAIL reset_pdata: got %h want 00", p_data); end
    tests_run++;
    if ({sampled_bit, par_chk_en, data_valid, par_err_flag, stop_err, strt_glitch} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 000000",
               {sampled_bit, par_chk_en, data_valid, par_err_flag, stop_err, strt_glitch});
    end
  endtask

  task automatic test_basic;
    int t0, n0, p0;
    n0 = obs_data_q.size();
    p0 = pce_cnt;
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    idle(10);
    tests_run++;
    if (obs_data_q.size() !== n0 + 1) begin
      tests_failed++; $display("FAIL basic_dv_count: got %0d want 1", obs_data_q.size() - n0);
    end else begin
      tests_run++;
      if (obs_cyc_q[n0] - t0 !== 80) begin
        tests_failed++; $display("FAIL basic_dv_latency: got %0d want 80", obs_cyc_q[n0] - t0);
      end
      tests_run++;
      if (obs_data_q[n0] !== 8'hA5) begin
        tests_failed++; $display("FAIL basic_dv_data: got %h want a5", obs_data_q[n0]);
      end
    end
    tests_run++;
    if (p_data !== 8'hA5) begin tests_failed++; $display("FAIL basic_pdata: got %h want a5", p_data); end
    tests_run++;
    if (stop_err !== 1'b0) begin tests_failed++; $display("FAIL basic_stop_err: got %b want 0", stop_err); end
    tests_run++;
    if (pce_cnt !== p0) begin tests_failed++; $display("FAIL basic_no_par_chk: got %0d strobes want 0", pce_cnt - p0); end
  endtask

  task automatic test_start_glitch;
    int t0, n0, s0;
    n0 = obs_data_q.size();
    s0 = sg_cnt;
    prescale = 6'd8;
    @(negedge clk);
    t0 = cyc;
    rx_in = 1'b0;
    idle(0);
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk); rx_in = 1'b0;
    idle(20);
    tests_run++;
    if (sg_cnt !== s0 + 1) begin
      tests_failed++; $display("FAIL glitch_count: got %0d want 1", sg_cnt - s0);
    end else begin
      tests_run++;
      if (sg_cyc - t0 !== 7) begin tests_failed++; $display("FAIL glitch_time: got %0d want 7", sg_cyc - t0); end
    end
    tests_run++;
    if (state_o !== 3'd0) begin tests_failed++; $display("FAIL glitch_idle: got %0d want 0", state_o); end
    tests_run++;
    if (obs_data_q.size() !== n0) begin tests_failed++; $display("FAIL glitch_no_dv: got %0d pulses want 0", obs_data_q.size() - n0); end
    tests_run++;
    if (p_data !== 8'hA5) begin tests_failed++; $display("FAIL glitch_pdata: got %h want a5", p_data); end
  endtask

  task automatic test_parity_ok;
    int t0, n0, p0;
    n0 = obs_data_q.size();
    p0 = pce_cnt;
    send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, -1, -1, t0);
    idle(10);
    tests_run++;
    if (pce_cnt !== p0 + 1) begin
      tests_failed++; $display("FAIL par_chk_count: got %0d want 1", pce_cnt - p0);
    end else begin
      tests_run++;
      if (pce_cyc - t0 !== 159) begin tests_failed++; $display("FAIL par_chk_time: got %0d want 159", pce_cyc - t0); end
    end
    tests_run++;
    if (obs_data_q.size() !== n0 + 1) begin
      tests_failed++; $display("FAIL par_ok_dv_count: got %0d want 1", obs_data_q.size() - n0);
    end else begin
      tests_run++;
      if (obs_cyc_q[n0] - t0 !== 176) begin tests_failed++; $display("FAIL par_ok_latency: got %0d want 176", obs_cyc_q[n0] - t0); end
      tests_run++;
      if (obs_data_q[n0] !== 8'h3C) begin tests_failed++; $display("FAIL par_ok_data: got %h want 3c", obs_data_q[n0]); end
    end
    tests_run++;
    if (par_err_flag !== 1'b0) begin tests_failed++; $display("FAIL par_ok_flag: got %b want 0", par_err_flag); end
  endtask

  task automatic test_parity_bad;
    int t0, n0;
    n0 = obs_data_q.size();
    send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1, -1, -1, t0);
    idle(10);
    tests_run++;
    if (par_err_flag !== 1'b1) begin tests_failed++; $display("FAIL par_bad_flag: got %b want 1", par_err_flag); end
    tests_run++;
    if (obs_data_q.size() !== n0) begin tests_failed++; $display("FAIL par_bad_no_dv: got %0d pulses want 0", obs_data_q.size() - n0); end
    tests_run++;
    if (stop_err !== 1'b0) begin tests_failed++; $display("FAIL par_bad_stop_err: got %b want 0", stop_err); end
  endtask

  task automatic test_majority;
    int t0, n0;
    n0 = obs_data_q.size();
    // data bit 2 is frame bit 3; its middle sample is edge 4 at Prescale 8
    send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b1, 3 * 8 + 4, -1, t0);
    idle(10);
    tests_run++;
    if (obs_data_q.size() !== n0 + 1) begin
      tests_failed++; $display("FAIL maj_dv_count: got %0d want 1", obs_data_q.size() - n0);
    end else begin
      tests_run++;
      if (obs_data_q[n0] !== 8'h0F) begin tests_failed++; $display("FAIL maj_data: got %h want 0f", obs_data_q[n0]); end
    end
    tests_run++;
    if (par_err_flag !== 1'b0) begin tests_failed++; $display("FAIL maj_par_flag_cleared: got %b want 0", par_err_flag); end
  endtask

  task automatic test_stop_err;
    int t0, n0;
    n0 = obs_data_q.size();
    send_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, -1, -1, t0);
    idle(10);
    tests_run++;
    if (stop_err !== 1'b1) begin tests_failed++; $display("FAIL stop_err_flag: got %b want 1", stop_err); end
    tests_run++;
    if (obs_data_q.size() !== n0) begin tests_failed++; $display("FAIL stop_err_no_dv: got %0d pulses want 0", obs_data_q.size() - n0); end
    tests_run++;
    if (p_data !== 8'h81) begin tests_failed++; $display("FAIL stop_err_pdata: got %h want 81", p_data); end
  endtask

  task automatic test_back_to_back;
    int t0a, t0b, t0c, n0, n1;
    logic [7:0] exp_b;
    n0 = obs_data_q.size();
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(32, 8'h55, 1'b0, 1'b0, 1'b1, -1, -1, t0a);
    send_frame(32, 8'hAA, 1'b0, 1'b0, 1'b1, -1, -1, t0b);
    idle(5);
    tests_run++;
    if (t0b - t0a !== 320) begin tests_failed++; $display("FAIL b2b_gap: got %0d want 320", t0b - t0a); end
    tests_run++;
    if (obs_data_q.size() !== n0 + 2) begin
      tests_failed++; $display("FAIL b2b_dv_count: got %0d want 2", obs_data_q.size() - n0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_b = exp_q.pop_front();
        tests_run++;
        if (obs_data_q[n0+i] !== exp_b) begin
          tests_failed++; $display("FAIL b2b_data%0d: got %h want %h", i, obs_data_q[n0+i], exp_b);
        end
      end
      tests_run++;
      if (obs_cyc_q[n0+1] - t0b !== 320) begin
        tests_failed++; $display("FAIL b2b_latency: got %0d want 320", obs_cyc_q[n0+1] - t0b);
      end
    end
    tests_run++;
    if (stop_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_stop_err_cleared: got %b want 0", stop_err); end
    // third frame, cut off mid data bit 4 by reset
    n1 = obs_data_q.size();
    send_frame(32, 8'h33, 1'b0, 1'b0, 1'b1, -1, 5 * 32 + 16, t0c);
    @(negedge clk);
    rx_in = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (state_o !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_state: got %0d want 0", state_o); end
    tests_run++;
    if (p_data !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_pdata: got %h want 00", p_data); end
    tests_run++;
    if ({sampled_bit, par_chk_en, data_valid, par_err_flag, stop_err, strt_glitch} !== 6'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %b want 000000",
               {sampled_bit, par_chk_en, data_valid, par_err_flag, stop_err, strt_glitch});
    end
    idle(400);
    tests_run++;
    if (obs_data_q.size() !== n1) begin tests_failed++; $display("FAIL rst_mid_no_dv: got %0d pulses want 0", obs_data_q.size() - n1); end
    tests_run++;
    if (state_o !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_idle_after: got %0d want 0", state_o); end
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    test_reset();
    idle(5);
    test_basic();
    test_start_glitch();
    test_parity_ok();
    test_parity_bad();
    test_majority();
    test_stop_err();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Receive-side frame controller for the UART RX path. It oversamples the serial line and detects the start bit.
- It recovers each bit by majority vote and deserializes the data LSB-first. It sequences the parity and stop checks.
- It sits directly upstream of the RX parity checker. It drives that checker's sampled_bit, P_DATA and par_chk_en, and consumes its par_err.
- It produces a one-cycle data_valid pulse toward the receive data sink.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of Prescale input and internal edge counter.

Ports:
- CLK  input  1  system clock, oversampling rate (Prescale x baud).
- RST  input  1  reset; synchronous, active-high.
- RX_IN  input  1  serial line, idle high; already synchronized to CLK.
- Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  input  1  1 = frame carries a parity bit.
- par_err  input  1  from parity checker; combinational result of sampled_bit vs P_DATA.
- sampled_bit  output  1  majority-voted value of the current bit.
- P_DATA  output  DATA_WIDTH  deserialized data byte.
- par_chk_en  output  1  one-cycle strobe; parity checker evaluates while high.
- data_valid  output  1  one-cycle pulse; P_DATA is a good frame.
- par_err_flag  output  1  latched parity error of the last frame.
- stop_err  output  1  latched stop-bit error of the last frame.
- strt_glitch  output  1  one-cycle pulse; false start rejected.

Behaviour:
- Reset: all outputs 0, P_DATA = 0, state IDLE, counters 0. RST mid-frame aborts the frame to IDLE; no data_valid, flags cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- Edge counter edge_cnt:
  - Counts 0..Prescale-1 within each bit, then wraps to 0.
  - The IDLE cycle that samples RX_IN = 0 is edge 0 of the start bit; edge_cnt = 1 in the next cycle, state START.
- Bit counter: counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - RX_IN is captured at edges Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The majority of those three is registered into sampled_bit. It is visible from edge Prescale/2+2 and held until the next bit's update.
- Bit-end actions, taken at edge Prescale-1 of each bit:
  - START: if sampled_bit = 1, pulse strt_glitch and go to IDLE. Otherwise go to DATA; bit counter = 0.
  - DATA:
    - Shift sampled_bit into P_DATA MSB, shifting right, so after DATA_WIDTH bits P_DATA[0] = first received bit.
    - After the last data bit, go to PARITY if PAR_EN = 1, else STOP.
  - PARITY: par_chk_en = 1 for exactly this cycle; par_err is registered into the internal frame parity flag. Then go to STOP.
  - STOP:
    - stop_err <= ~sampled_bit.
    - par_err_flag <= frame parity flag (0 if PAR_EN = 0).
    - If sampled_bit = 1 and no parity error, data_valid = 1 in the next cycle.
    - Go to IDLE.
- par_chk_en is never high outside PARITY. P_DATA is stable while par_chk_en is high. P_DATA holds until the first data shift of the next frame.
- Latency: with t0 = the cycle RX_IN is first sampled low, data_valid is high in cycle t0 + 10·Prescale, or t0 + 11·Prescale with PAR_EN = 1.
- Back-to-back frames: IDLE sees the next falling edge immediately after STOP; there is no dead cycle requirement.
- par_err_flag and stop_err update only at STOP end. They are cleared at the next valid start-bit confirmation.
- PAR_EN and Prescale are sampled only in IDLE and held internally for the frame; changes mid-frame are ignored.
- Illegal Prescale values give undefined timing but must not lock the FSM.

Test Plan:
- Prescale = 8, PAR_EN = 0, frame 0xA5 with stop = 1:
  - data_valid high exactly one cycle at t0+80.
  - P_DATA = 0xA5; stop_err = 0; par_chk_en never asserted.
- Prescale = 16, PAR_EN = 1, data 0x3C, parity bit driven to match, with par_err stubbed/checker connected:
  - par_chk_en high one cycle at t0+9·16+15.
  - data_valid at t0+176; par_err_flag = 0.
- Same frame with the parity bit inverted: par_err_flag = 1, no data_valid, stop_err = 0.
- RX_IN low for 3 cycles, then high (Prescale = 8): strt_glitch pulse at t0+7, return to IDLE, no data_valid, P_DATA unchanged.
- Data bit 2 of 0x0F with a single-cycle inverted glitch at its middle sample: majority vote gives P_DATA = 0x0F. Separately, stop bit driven 0 gives stop_err = 1 and no data_valid.
- Two back-to-back frames 0x55, 0xAA at Prescale = 32, then RST asserted at data bit 4 of a third frame:
  - two data_valid pulses with the correct bytes.
  - after reset, outputs are 0 and state is IDLE; no pulse.
